divisor_frequencia_multicanal: RTL

- Parametrised successor to the ripple T-flip-flop clock divider.
- One shared prescaler turns the system clock into a base tick. NUM_CH independent channels divide that base tick by runtime-loadable ratios.
- Each channel outputs a one-cycle enable pulse and a 50% square wave, both in the clk domain with no derived clocks.
- Feeds the elevator controller's timers (door, floor travel, display scan) with exact, programmable periods instead of fixed powers of two.

---
 rtl/divisor_frequencia_multicanal.sv | 110 +++++++++++
 1 files changed

// File: rtl/divisor_frequencia_multicanal.sv
// divisor_frequencia_multicanal: shared prescaler + NUM_CH programmable
// divider channels. Each channel emits a one-cycle tick and a ~50% square
// wave, all in the clk domain (no derived clocks).
// Optional: define DIVISOR_TICK_COUNT_EN to add per-channel 8-bit tick
// counters on port tick_cnt.
module divisor_frequencia_multicanal #(
  parameter int PRESCALE = 50000000,
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_CH-1:0]                               en,
  input  logic                                            load,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  load_ch,
  input  logic [DIV_W-1:0]                                load_div,
  output logic                                            fs,
  output logic [NUM_CH-1:0]                               tick,
  output logic [NUM_CH-1:0]                               wave
`ifdef DIVISOR_TICK_COUNT_EN
  ,
  output logic [NUM_CH*8-1:0]                             tick_cnt
`endif
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          base;

  // base is the edge on which the prescaler wraps; channels advance on it
  // so their ticks line up with fs.
  assign base = (pre_cnt == PMAX);

  // Free-running prescaler; never gated by en.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      fs      <= 1'b0;
    end else begin
      fs      <= base;
      pre_cnt <= base ? '0 : pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [DIV_W-1:0] RDIV = DIV_W'(DEF_DIV << i);

    logic [DIV_W-1:0] div, cnt, nxt, half;
    logic             ld, wrap, tick_r, wave_r;

    // Out-of-range load_ch never matches any channel, so it is ignored.
    assign ld   = load && (load_ch == CW'(i));
    assign nxt  = cnt + 1'b1;
    assign wrap = (cnt == div - 1'b1);
    // Wave drops once cnt reaches div - div/2, so odd divisors stay high
    // for ceil(div/2) base ticks and div=1 never drops.
    assign half = div - (div >> 1);

    // Channel divider: load beats wrap, div=0 parks the channel, en=0 holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        div    <= RDIV;
        cnt    <= '0;
        tick_r <= 1'b0;
        wave_r <= 1'b0;
      end else if (ld) begin
        div    <= load_div;
        cnt    <= '0;
        tick_r <= 1'b0;
        wave_r <= 1'b0;
      end else if (div == '0) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        wave_r <= 1'b0;
      end else if (base && en[i]) begin
        if (wrap) begin
          cnt    <= '0;
          tick_r <= 1'b1;
          wave_r <= 1'b1;
        end else begin
          cnt    <= nxt;
          tick_r <= 1'b0;
          if (nxt == half) wave_r <= 1'b0;
        end
      end else begin
        tick_r <= 1'b0;
      end
    end

    assign tick[i] = tick_r;
    assign wave[i] = wave_r;

`ifdef DIVISOR_TICK_COUNT_EN
    logic [7:0] tcnt;

    // Wrap-around count of emitted ticks; cleared by reset or a load.
    always_ff @(posedge clk) begin
      if (rst || ld) tcnt <= '0;
      else if (tick_r) tcnt <= tcnt + 1'b1;
    end

    assign tick_cnt[i*8 +: 8] = tcnt;
`endif
  end

endmodule
